uart_tx_fifo: RTL and testbench

Buffered UART transmitter that sits directly downstream of the CPU execution stage's store path. It accepts byte writes targeted at UART_ADDR, queues them in a FIFO, and serializes them 8N1 onto uart_tx. It replaces the unbuffered single-byte transmitter, so back-to-back stores from the core are not lost while a frame is in flight. It exposes status and overflow flags so the core can poll them through a load path.

---
 rtl/uart_tx_fifo_if.sv | 51 +++++
 rtl/uart_tx_fifo.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
//   Store-path / status bundle between the CPU core and the buffered UART
//   transmitter.
//
//   uart_we   core -> uart  write strobe (store to UART_ADDR), 1 byte/cycle
//   wr_data   core -> uart  byte to enqueue, sampled with uart_we
//   ovf_clr   core -> uart  synchronous clear of the sticky overflow flag
//   tx_full   uart -> core  FIFO holds 2**DEPTH_LOG2 entries
//   tx_empty  uart -> core  FIFO holds no entries
//   tx_busy   uart -> core  FIFO not empty or serializer not idle
//   tx_count  uart -> core  FIFO occupancy (DEPTH_LOG2+1 bits)
//   tx_ovf    uart -> core  sticky: a write was dropped on a full FIFO
//
//   master : the core side (drives the write strobe, reads status)
//   slave  : the transmitter side
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  uart_we;
  logic [7:0]            wr_data;
  logic                  ovf_clr;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  tx_busy;
  logic [DEPTH_LOG2:0]   tx_count;
  logic                  tx_ovf;

  modport master (
    output uart_we,
    output wr_data,
    output ovf_clr,
    input  tx_full,
    input  tx_empty,
    input  tx_busy,
    input  tx_count,
    input  tx_ovf
  );

  modport slave (
    input  uart_we,
    input  wr_data,
    input  ovf_clr,
    output tx_full,
    output tx_empty,
    output tx_busy,
    output tx_count,
    output tx_ovf
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered 8N1 UART transmitter fed by the EX-stage store path. Bytes are
//   queued in a 2**DEPTH_LOG2 entry FIFO and serialized LSB first onto
//   uart_tx. A write to a full FIFO is dropped (unless the serializer pops in
//   the same cycle) and latches the sticky tx_ovf flag.
//
//   Parameters
//     CLK_HZ      system clock frequency in Hz
//     BAUD        line rate; CLKS_PER_BIT = CLK_HZ/BAUD (must be >= 2)
//     DEPTH_LOG2  log2 of the FIFO depth (>= 1)
//
//   Ports
//     clk      system clock, rising edge
//     rst_n    asynchronous active-low reset; abandons any frame in flight
//     bus      uart_tx_fifo_if.slave: write strobe/data, ovf_clr, status
//     uart_tx  serial line, idle high, driven from a flop
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus,
  output logic           uart_tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned DEPTH        = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // -------------------------------------------------------------------------
  // FIFO storage and pointers (one extra MSB to tell full from empty)
  // -------------------------------------------------------------------------
  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                push_ok;
  logic                ovf_set;
  logic                ovf_q;

  // -------------------------------------------------------------------------
  // Serializer state
  // -------------------------------------------------------------------------
  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    baud_cnt;
  logic                bit_end;
  logic [2:0]          bit_idx_q;
  logic [2:0]          bit_idx_d;
  logic [7:0]          shift_q;
  logic                tx_d;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  // Pop is only taken from IDLE; the byte pushed this cycle is not visible
  // until the next one, so there is no write-to-read bypass.
  assign pop     = (state_q == S_IDLE) && !fifo_empty;
  // A same-cycle pop frees the head slot, so a push into a full FIFO is
  // still accepted; the write lands on the slot being read at this edge.
  assign push_ok = bus.uart_we && (!fifo_full || pop);
  assign ovf_set = bus.uart_we && fifo_full && !pop;

  assign bit_end = (baud_cnt == CNT_LAST);

  // -------------------------------------------------------------------------
  // FIFO pointers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage array carries no reset; contents are only observed behind rd_ptr.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky overflow flag: a dropped write beats a same-cycle clear
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end && (bit_idx_q == 3'd7)) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // uart_tx is a flop, so the line level is decoded from the state being
  // entered rather than the current one; this keeps the start bit aligned
  // with the pop edge while still presenting a glitch-free register output.
  // -------------------------------------------------------------------------
  always_comb begin
    bit_idx_d = bit_idx_q;
    if (state_q == S_START) begin
      bit_idx_d = '0;
    end else if ((state_q == S_DATA) && bit_end) begin
      bit_idx_d = bit_idx_q + 3'd1;
    end
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: baud counter, bit index, shift register, line flop
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      uart_tx   <= 1'b1;
    end else begin
      if ((state_q == S_IDLE) || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
      bit_idx_q <= bit_idx_d;
      if (pop) begin
        shift_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      end
      uart_tx <= tx_d;
    end
  end

  // -------------------------------------------------------------------------
  // Status
  // -------------------------------------------------------------------------
  assign bus.tx_full  = fifo_full;
  assign bus.tx_empty = fifo_empty;
  assign bus.tx_count = wr_ptr - rd_ptr;
  assign bus.tx_busy  = (state_q != S_IDLE) || !fifo_empty;
  assign bus.tx_ovf   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo with CLKS_PER_BIT=8 and a 4-entry
//   FIFO. Accepted bytes go into a scoreboard queue; a line monitor decodes
//   each 8N1 frame from uart_tx and compares it with the queue head.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int unsigned CLK_HZ     = 80;
  localparam int unsigned BAUD       = 10;
  localparam int unsigned DEPTH_LOG2 = 2;
  localparam int unsigned CPB        = 8;
  localparam int unsigned FRAME      = 10 * CPB;

  logic clk;
  logic rst_n;
  logic uart_tx;

  uart_tx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_tx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .uart_tx (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [7:0] sb [$];
  int         start_times [$];
  int         cyc = 0;

  // monitor state
  bit         mon_busy = 0;
  int         mon_t    = 0;
  logic [7:0] mon_rx   = '0;

  // occupancy tracking
  bit          track = 0;
  int unsigned maxc  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] status();
    return {uart_tx, bus.tx_empty, bus.tx_full, bus.tx_busy, bus.tx_count, bus.tx_ovf};
  endfunction

  // idle, reset-like status: line high, empty, not full, not busy, count 0, no ovf
  localparam logic [7:0] ST_IDLE = 8'hC0;

  // caller is at a falling edge; the write is taken at the next rising edge
  task automatic push(input logic [7:0] b, input bit accepted);
    bus.uart_we = 1'b1;
    bus.wr_data = b;
    if (accepted) sb.push_back(b);
    @(negedge clk);
    bus.uart_we = 1'b0;
  endtask

  // line monitor: t counts cycles from the first low (start) cycle
  always @(negedge clk) begin
    cyc++;
    if (track && (int'(bus.tx_count) > int'(maxc))) maxc = bus.tx_count;
    if (!rst_n) begin
      mon_busy = 0;
    end else if (!mon_busy) begin
      if (uart_tx == 1'b0) begin
        mon_busy = 1;
        mon_t    = 0;
        start_times.push_back(cyc);
      end
    end else begin
      mon_t++;
      if (mon_t == CPB / 2) check("start_bit", uart_tx, 1'b0);
      if ((mon_t >= 12) && (mon_t <= 68) && ((mon_t - 4) % 8 == 0))
        mon_rx[(mon_t - 12) / 8] = uart_tx;
      if (mon_t == 76) begin
        check("stop_bit", uart_tx, 1'b1);
        check("sb_nonempty", sb.size() > 0, 1'b1);
        if (sb.size() > 0) check("rx_byte", mon_rx, sb.pop_front());
      end
      if (mon_t == FRAME - 1) mon_busy = 0;
    end
  end

  initial begin
    logic [7:0] b55;
    logic       exp_bit;
    int         idx;

    rst_n       = 1'b0;
    bus.uart_we = 1'b0;
    bus.wr_data = '0;
    bus.ovf_clr = 1'b0;

    // 1. reset and idle
    repeat (3) @(negedge clk);
    check("in_reset", status(), ST_IDLE);
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      check("idle", status(), ST_IDLE);
    end

    // 2. single byte 0x55, cycle-exact waveform
    b55 = 8'h55;
    push(b55, 1);
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      if (i <= CPB) exp_bit = 1'b0;
      else if (i <= 9 * CPB) begin
        idx     = (i - CPB - 1) / CPB;
        exp_bit = b55[idx];
      end else exp_bit = 1'b1;
      check($sformatf("wave_%0d", i), uart_tx, exp_bit);
    end
    check("busy_last_stop", bus.tx_busy, 1'b1);
    @(negedge clk);
    check("busy_fall", bus.tx_busy, 1'b0);
    check("after_single", status(), ST_IDLE);
    repeat (5) @(negedge clk);

    // 3. burst into a full FIFO
    start_times.delete();
    for (int i = 1; i <= 5; i++) push(8'(i), 1);
    check("burst_count", bus.tx_count, 4);
    check("burst_full", bus.tx_full, 1'b1);
    push(8'h06, 0);
    check("drop_ovf", bus.tx_ovf, 1'b1);
    check("drop_count", bus.tx_count, 4);

    // 4. overflow set beats clear, then clear alone
    bus.ovf_clr = 1'b1;
    push(8'h07, 0);
    bus.ovf_clr = 1'b0;
    check("ovf_set_wins", bus.tx_ovf, 1'b1);
    check("ovf_count", bus.tx_count, 4);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", bus.tx_ovf, 1'b0);

    repeat (5 * (FRAME + 1) + 20) @(negedge clk);
    check("burst_frames", start_times.size(), 5);
    for (int i = 1; i < start_times.size(); i++)
      check($sformatf("gap_%0d", i), start_times[i] - start_times[i-1], FRAME + 1);
    check("burst_drained", sb.size(), 0);
    check("burst_idle", status(), ST_IDLE);

    // 5. pointer wrap: 10 bytes in pairs
    track = 1;
    maxc  = 0;
    for (int p = 0; p < 5; p++) begin
      push(8'hA0 + 8'(2 * p), 1);
      push(8'hA1 + 8'(2 * p), 1);
      check("pair_count", bus.tx_count, 1);
      repeat (2 * (FRAME + 1) + 10) @(negedge clk);
    end
    track = 0;
    check("wrap_max_le4", maxc <= 4, 1'b1);
    check("wrap_drained", sb.size(), 0);

    // 6. reset during DATA bit 3 of 0xFF
    push(8'hFF, 1);
    repeat (35) @(negedge clk);
    check("pre_reset_busy", bus.tx_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", status(), ST_IDLE);
    sb.delete();
    repeat (2) @(negedge clk);
    check("held_reset", status(), ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    push(8'h3C, 1);
    repeat (FRAME + 20) @(negedge clk);
    check("post_reset_drained", sb.size(), 0);
    check("post_reset_idle", status(), ST_IDLE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
